// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types for the two-requester memory arbiter: the
//               arbiter state encoding and the requester identifiers, plus a
//               helper that returns the opposite requester.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
  endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_req_slot.sv
`default_nettype none
// ============================================================================
// Module      : req_slot
// Description : Single-entry capture slot for one requester. A request pulse
//               is captured only while the slot is empty; a pulse arriving
//               while a request is already held is dropped so the held
//               request is never overwritten. The arbiter clears the slot
//               when the held request completes.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_en            - one-cycle request pulse
//               i_wren          - write qualifier captured with i_en
//               i_addr/i_wdata  - request address / write data
//               i_clear         - completion of the held request
//               o_pending       - slot holds an outstanding request
//               o_wren/o_addr/o_wdata - captured request contents
// Revision    : 1.0 - initial release
// ============================================================================
module req_slot #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_wren,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_clear,
  output logic              o_pending,
  output logic              o_wren,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pending <= 1'b0;
      o_wren    <= 1'b0;
      o_addr    <= '0;
      o_wdata   <= '0;
    end else if (i_clear) begin
      // The held request is still pending in its completion cycle, so a
      // pulse in that same cycle is dropped like any other duplicate.
      o_pending <= 1'b0;
    end else if (i_en && !o_pending) begin
      o_pending <= 1'b1;
      o_wren    <= i_wren;
      o_addr    <= i_addr;
      o_wdata   <= i_wdata;
    end
  end

endmodule : req_slot
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (fetch / data) arbiter in front of a single
//               backend memory port. Each side has a capture slot; in IDLE a
//               fresh request pulse bypasses the slot so it can be issued on
//               the next edge. Ties go to the side not granted last. One
//               transaction is outstanding at a time; a WAIT-cycle counter
//               forces completion with all-ones data if the backend never
//               answers.
// Ports       : clk, reset                  - clock, async active-high reset
//               icache_en/addr              - fetch read request
//               icache_rdata/done           - fetch response
//               dcache_en/wren/addr/wdata   - data-side request
//               dcache_rdata/done           - data-side response
//               mem_en/wren/addr/wdata      - backend request (held)
//               mem_rdata/done              - backend response
//               busy                        - transaction outstanding
//               mem_timeout                 - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_en,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic [DATA_W-1:0] icache_rdata,
  output logic              icache_done,
  input  logic              dcache_en,
  input  logic              dcache_wren,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] dcache_wdata,
  output logic [DATA_W-1:0] dcache_rdata,
  output logic              dcache_done,
  output logic              mem_en,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy,
  output logic              mem_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t         r_state;
  req_id_t            r_grant;
  req_id_t            r_last_grant;
  logic [CNT_W-1:0]   r_wait_cnt;

  logic               w_i_pend, w_i_slot_wren;
  logic [ADDR_W-1:0]  w_i_slot_addr;
  logic [DATA_W-1:0]  w_i_slot_wdata;
  logic               w_d_pend, w_d_slot_wren;
  logic [ADDR_W-1:0]  w_d_slot_addr;
  logic [DATA_W-1:0]  w_d_slot_wdata;

  logic               w_i_req, w_d_req;
  logic               w_i_wren, w_d_wren;
  logic [ADDR_W-1:0]  w_i_addr, w_d_addr;
  logic [DATA_W-1:0]  w_i_wdata, w_d_wdata;
  req_id_t            w_winner;
  logic               w_in_wait, w_tmo_hit, w_complete;
  logic               w_i_clear, w_d_clear;
  logic [DATA_W-1:0]  w_cpl_data;

  req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_icache_slot (
    .clk       (clk),
    .rst       (reset),
    .i_en      (icache_en),
    .i_wren    (1'b0),
    .i_addr    (icache_addr),
    .i_wdata   ({DATA_W{1'b0}}),
    .i_clear   (w_i_clear),
    .o_pending (w_i_pend),
    .o_wren    (w_i_slot_wren),
    .o_addr    (w_i_slot_addr),
    .o_wdata   (w_i_slot_wdata)
  );

  req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dcache_slot (
    .clk       (clk),
    .rst       (reset),
    .i_en      (dcache_en),
    .i_wren    (dcache_wren),
    .i_addr    (dcache_addr),
    .i_wdata   (dcache_wdata),
    .i_clear   (w_d_clear),
    .o_pending (w_d_pend),
    .o_wren    (w_d_slot_wren),
    .o_addr    (w_d_slot_addr),
    .o_wdata   (w_d_slot_wdata)
  );

  // Effective request: a held request, or a pulse this cycle that bypasses
  // the slot. A held request takes precedence over the incoming pulse,
  // which the slot drops anyway.
  assign w_i_req   = w_i_pend | icache_en;
  assign w_d_req   = w_d_pend | dcache_en;
  assign w_i_addr  = w_i_pend ? w_i_slot_addr  : icache_addr;
  assign w_i_wren  = w_i_pend ? w_i_slot_wren  : 1'b0;
  assign w_i_wdata = w_i_pend ? w_i_slot_wdata : {DATA_W{1'b0}};
  assign w_d_addr  = w_d_pend ? w_d_slot_addr  : dcache_addr;
  assign w_d_wren  = w_d_pend ? w_d_slot_wren  : dcache_wren;
  assign w_d_wdata = w_d_pend ? w_d_slot_wdata : dcache_wdata;

  always_comb begin
    w_winner = REQ_ICACHE;
    if (w_i_req && w_d_req) begin
      w_winner = other_req(r_last_grant);
    end else if (w_d_req) begin
      w_winner = REQ_DCACHE;
    end
  end

  // Backend response wins over a timeout landing in the same cycle.
  assign w_in_wait  = (r_state == WAIT);
  assign w_tmo_hit  = w_in_wait && !mem_done && (r_wait_cnt == C_CNT_LAST);
  assign w_complete = (w_in_wait && mem_done) || w_tmo_hit;
  assign w_cpl_data = mem_done ? mem_rdata : {DATA_W{1'b1}};
  assign w_i_clear  = w_complete && (r_grant == REQ_ICACHE);
  assign w_d_clear  = w_complete && (r_grant == REQ_DCACHE);

  assign busy = w_in_wait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= REQ_ICACHE;
      r_last_grant <= REQ_ICACHE;
      r_wait_cnt   <= '0;
      mem_en       <= 1'b0;
      mem_wren     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      icache_rdata <= '0;
      icache_done  <= 1'b0;
      dcache_rdata <= '0;
      dcache_done  <= 1'b0;
      mem_timeout  <= 1'b0;
    end else begin
      mem_en      <= 1'b0;
      icache_done <= 1'b0;
      dcache_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_i_req || w_d_req) begin
            r_state      <= WAIT;
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_wait_cnt   <= '0;
            mem_en       <= 1'b1;
            if (w_winner == REQ_DCACHE) begin
              mem_wren  <= w_d_wren;
              mem_addr  <= w_d_addr;
              mem_wdata <= w_d_wdata;
            end else begin
              mem_wren  <= w_i_wren;
              mem_addr  <= w_i_addr;
              mem_wdata <= w_i_wdata;
            end
          end
        end
        WAIT: begin
          if (w_complete) begin
            r_state <= IDLE;
            if (w_tmo_hit) begin
              mem_timeout <= 1'b1;
            end
            if (r_grant == REQ_DCACHE) begin
              dcache_rdata <= w_cpl_data;
              dcache_done  <= 1'b1;
            end else begin
              icache_rdata <= w_cpl_data;
              icache_done  <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed scenarios are
//               followed by a randomized run; every cycle the DUT outputs are
//               compared with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_en;
  logic [63:0] icache_addr;
  logic [63:0] icache_rdata;
  logic        icache_done;
  logic        dcache_en, dcache_wren;
  logic [63:0] dcache_addr, dcache_wdata, dcache_rdata;
  logic        dcache_done;
  logic        mem_en, mem_wren;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done;
  logic        busy, mem_timeout;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .icache_en    (icache_en),
    .icache_addr  (icache_addr),
    .icache_rdata (icache_rdata),
    .icache_done  (icache_done),
    .dcache_en    (dcache_en),
    .dcache_wren  (dcache_wren),
    .dcache_addr  (dcache_addr),
    .dcache_wdata (dcache_wdata),
    .dcache_rdata (dcache_rdata),
    .dcache_done  (dcache_done),
    .mem_en       (mem_en),
    .mem_wren     (mem_wren),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .busy         (busy),
    .mem_timeout  (mem_timeout)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: index 0 = fetch side, 1 = data side.
  logic        m_pend   [2];
  logic        m_pwren  [2];
  logic [63:0] m_paddr  [2];
  logic [63:0] m_pwdata [2];
  logic [63:0] m_rdata  [2];
  logic        m_done   [2];
  logic        m_busy, m_tmo, m_men, m_mwren;
  logic [63:0] m_maddr, m_mwdata;
  int          m_gnt, m_last, m_wcyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_pend[s] = 1'b0; m_pwren[s] = 1'b0; m_paddr[s] = '0;
      m_pwdata[s] = '0; m_rdata[s] = '0; m_done[s] = 1'b0;
    end
    m_busy = 1'b0; m_tmo = 1'b0; m_men = 1'b0; m_mwren = 1'b0;
    m_maddr = '0; m_mwdata = '0; m_gnt = 0; m_last = 0; m_wcyc = 0;
  endtask

  task automatic check_all();
    chk1("mem_en", mem_en, m_men);
    chk1("mem_wren", mem_wren, m_mwren);
    chk("mem_addr", mem_addr, m_maddr);
    chk("mem_wdata", mem_wdata, m_mwdata);
    chk1("icache_done", icache_done, m_done[0]);
    chk1("dcache_done", dcache_done, m_done[1]);
    chk("icache_rdata", icache_rdata, m_rdata[0]);
    chk("dcache_rdata", dcache_rdata, m_rdata[1]);
    chk1("busy", busy, m_busy);
    chk1("mem_timeout", mem_timeout, m_tmo);
  endtask

  task automatic drive_zero();
    icache_en = 1'b0; icache_addr = '0; dcache_en = 1'b0; dcache_wren = 1'b0;
    dcache_addr = '0; dcache_wdata = '0; mem_done = 1'b0; mem_rdata = '0;
  endtask

  // Asynchronous reset applied away from the clock edge.
  task automatic do_reset();
    reset = 1'b1;
    drive_zero();
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model, clock, compare.
  task automatic step(input logic ien, input logic [63:0] iaddr,
                      input logic den, input logic dwren,
                      input logic [63:0] daddr, input logic [63:0] dwdata,
                      input logic mdone, input logic [63:0] mrdata);
    int w;
    icache_en = ien; icache_addr = iaddr;
    dcache_en = den; dcache_wren = dwren; dcache_addr = daddr; dcache_wdata = dwdata;
    mem_done = mdone; mem_rdata = mrdata;

    m_men = 1'b0; m_done[0] = 1'b0; m_done[1] = 1'b0;
    // A side accepts a new request only when it has none outstanding.
    if (ien && !m_pend[0]) begin
      m_pend[0] = 1'b1; m_paddr[0] = iaddr; m_pwren[0] = 1'b0; m_pwdata[0] = '0;
    end
    if (den && !m_pend[1]) begin
      m_pend[1] = 1'b1; m_paddr[1] = daddr; m_pwren[1] = dwren; m_pwdata[1] = dwdata;
    end
    if (!m_busy) begin
      if (m_pend[0] || m_pend[1]) begin
        if (m_pend[0] && m_pend[1]) w = 1 - m_last;
        else w = m_pend[1] ? 1 : 0;
        m_men = 1'b1; m_maddr = m_paddr[w]; m_mwren = m_pwren[w]; m_mwdata = m_pwdata[w];
        m_busy = 1'b1; m_gnt = w; m_last = w; m_wcyc = 0;
      end
    end else begin
      m_wcyc++;
      if (mdone || m_wcyc == TMO) begin
        m_rdata[m_gnt] = mdone ? mrdata : 64'hFFFF_FFFF_FFFF_FFFF;
        if (!mdone) m_tmo = 1'b1;
        m_done[m_gnt] = 1'b1;
        m_pend[m_gnt] = 1'b0;
        m_busy = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic respond(input logic [63:0] d);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, d);
  endtask

  int nge;

  initial begin
    drive_zero();
    reset = 1'b1;
    do_reset();
    chk1("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_timeout", mem_timeout, 1'b0);

    // Single data-side read.
    step(1'b0, '0, 1'b1, 1'b0, 64'h1000, '0, 1'b0, '0);
    chk1("rd_men", mem_en, 1'b1);
    chk("rd_addr", mem_addr, 64'h1000);
    idle(2);
    chk1("rd_men_pulse", mem_en, 1'b0);
    respond(64'hDEAD);
    chk1("rd_dcache_done", dcache_done, 1'b1);
    chk("rd_rdata", dcache_rdata, 64'hDEAD);
    chk1("rd_icache_done", icache_done, 1'b0);
    idle(1);
    chk1("rd_done_pulse", dcache_done, 1'b0);

    // Simultaneous requests after reset: data side wins first tie.
    do_reset();
    step(1'b1, 64'h40_0000, 1'b1, 1'b1, 64'h2000, 64'h55, 1'b0, '0);
    chk("tie_addr", mem_addr, 64'h2000);
    chk1("tie_wren", mem_wren, 1'b1);
    chk("tie_wdata", mem_wdata, 64'h55);
    idle(1);
    respond(64'h77);
    chk1("tie_gap_men", mem_en, 1'b0);
    chk("tie_write_rdata", dcache_rdata, 64'h77);
    idle(1);
    chk1("tie_ic_men", mem_en, 1'b1);
    chk("tie_ic_addr", mem_addr, 64'h40_0000);
    chk1("tie_ic_wren", mem_wren, 1'b0);
    respond(64'h99);
    idle(1);
    chk("tie_ic_rdata", icache_rdata, 64'h99);
    chk("tie_dc_hold", dcache_rdata, 64'h77);

    // Continuous re-requests: grants alternate, data side first.
    do_reset();
    nge = 0;
    for (int k = 0; k < 100 && nge < 8; k++) begin
      step(1'b1, 64'h4000_0000, 1'b1, 1'b0, 64'h2000_0000, '0, m_busy, 64'(k));
      if (mem_en) begin
        chk1("alt_side", mem_addr[30], (nge % 2) == 1);
        nge++;
      end
    end
    chk("alt_count", 64'(nge), 64'd8);
    idle(4);

    // Duplicate pulse while pending is dropped.
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0, 64'h1000, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 64'h3000, '0, 1'b0, '0);
    chk("dup_addr", mem_addr, 64'h1000);
    respond(64'h1234);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk1("dup_no_reissue", mem_en, 1'b0);
    end

    // Backend never answers: forced completion after TMO wait cycles.
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0, 64'h5000, '0, 1'b0, '0);
    for (int i = 0; i < TMO - 1; i++) begin
      idle(1);
      chk1("tmo_early_done", dcache_done, 1'b0);
    end
    idle(1);
    chk1("tmo_done", dcache_done, 1'b1);
    chk("tmo_rdata", dcache_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk1("tmo_flag", mem_timeout, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 64'h5100, 64'h1, 1'b0, '0);
    respond(64'h0);
    idle(3);
    chk1("tmo_sticky", mem_timeout, 1'b1);
    do_reset();
    chk1("tmo_cleared", mem_timeout, 1'b0);

    // Reset mid-WAIT, then a stray backend completion.
    step(1'b0, '0, 1'b1, 1'b0, 64'h6000, '0, 1'b0, '0);
    idle(2);
    do_reset();
    chk1("mid_busy", busy, 1'b0);
    respond(64'hBAD);
    chk1("stray_done", dcache_done, 1'b0);
    chk1("stray_busy", busy, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 64'h7000, '0, 1'b0, '0);
    chk1("post_rst_men", mem_en, 1'b1);
    chk("post_rst_addr", mem_addr, 64'h7000);
    respond(64'h42);
    idle(1);
    chk("post_rst_rdata", dcache_rdata, 64'h42);

    // Randomized traffic, including stray completions while idle.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 3) == 0, {$urandom, $urandom},
           $urandom_range(0, 3) == 0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 3) == 0, {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning request address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data width.
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning maximum WAIT cycles before forced completion.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 icache_en  in  1  one-cycle read request pulse, fetch side.
REQ-008 icache_addr  in  ADDR_W  fetch address, valid with icache_en.
REQ-009 icache_rdata  out  DATA_W  fetch read data, valid with icache_done.
REQ-010 icache_done  out  1  one-cycle completion pulse, fetch side.
REQ-011 dcache_en / dcache_wren  in  1 each  one-cycle request pulse / write qualifier, Mem side.
REQ-012 dcache_addr / dcache_wdata  in  ADDR_W / DATA_W  Mem request address / write data.
REQ-013 dcache_rdata / dcache_done  out  DATA_W / 1  Mem read data / one-cycle completion pulse.
REQ-014 mem_en / mem_wren  out  1 each  one-cycle backend request pulse / write qualifier.
REQ-015 mem_addr / mem_wdata  out  ADDR_W / DATA_W  backend address / write data, held until completion.
REQ-016 mem_rdata / mem_done  in  DATA_W / 1  backend read data / completion pulse.
REQ-017 busy  out  1  high while state is WAIT.
REQ-018 mem_timeout  out  1  sticky timeout flag.

Function
REQ-019 Each requester SHALL own a capture slot (pending, wren, addr, wdata) loaded on its en pulse; icache slot wren always 0.
REQ-020 An en pulse while that requester's slot is pending SHALL be ignored; the slot SHALL NOT be overwritten.
REQ-021 FSM states SHALL be IDLE and WAIT only.
REQ-022 In IDLE, effective request per side SHALL be pending OR en (bypass), so en in cycle 0 yields mem_en high in cycle 1.
REQ-023 If only one side requests in IDLE, it SHALL be granted; if both, the side not granted last SHALL win.
REQ-024 On grant, mem_en SHALL pulse high exactly one cycle, mem_addr/mem_wdata/mem_wren SHALL be loaded from the winner, last_grant updated, state -> WAIT.
REQ-025 In WAIT, mem_done SHALL, at the same edge: clear the granted slot, load its rdata with mem_rdata, pulse its done one cycle, return to IDLE.
REQ-026 rdata SHALL update on every completion, read or write; the other side's rdata SHALL hold.
REQ-027 After completion in cycle k, the next mem_en SHALL be no earlier than cycle k+2.
REQ-028 A new en arriving in the same cycle as that requester's done pulse SHALL be accepted.
REQ-029 mem_done in IDLE SHALL be ignored.
REQ-030 A WAIT cycle counter SHALL clear on entry; reaching TIMEOUT SHALL complete the granted request with rdata all ones, set mem_timeout, return to IDLE.
REQ-031 The losing side's request SHALL remain pending and be granted on the next IDLE evaluation.

Reset
REQ-032 Reset SHALL force: state IDLE; slots cleared; all outputs 0; last_grant = icache (dcache wins first tie).
REQ-033 Reset mid-WAIT SHALL abandon the transaction; a late mem_done after reset SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the arbiter state enum (IDLE, WAIT) and requester-id enum (REQ_ICACHE, REQ_DCACHE).
REQ-035 The capture slot SHALL be a sub-module req_slot, instantiated twice.

Verification
REQ-036 Single dcache read 0x1000, mem_done after 3 cycles with 0xDEAD -> mem_en cycle 1, dcache_done one cycle with rdata 0xDEAD, icache_done stays 0.
REQ-037 Simultaneous icache_en 0x400000 and dcache_en write 0x2000/0x55 after reset -> dcache granted first, icache mem_en two cycles after dcache completes.
REQ-038 Both sides continuously re-requesting for 8 transactions -> grants strictly alternate.
REQ-039 Second dcache_en while pending with addr 0x3000 -> ignored; backend sees original address only.
REQ-040 mem_done never returned, TIMEOUT=16 -> done pulse after 16 WAIT cycles, rdata 0xFFFFFFFFFFFFFFFF, mem_timeout stays 1 until reset.
REQ-041 Reset asserted mid-WAIT, then stray mem_done -> no done pulse, busy 0, next request issues normally.
